// File: rtl/psum_collector_if.sv
// ---------------------------------------------------------------------------
// psum_collector_if
//   Bundles the signals between the systolic array / tile controller and the
//   partial-sum collector, plus the unified buffer write port it drives.
//
//   Tile control : Start, Base_Addr, Busy, Done, Skew_Err
//   Array side   : In_Valid[SIZE], Psum_In_0..7 (signed column outputs)
//   Buffer side  : Wr_en, Wr_Addr, Wr_Data_0..7
//
//   modport master : environment side (drives array/control inputs)
//   modport slave  : collector side (drives the write port and status)
// ---------------------------------------------------------------------------
interface psum_collector_if #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 2*SIZE+$clog2(SIZE),
    parameter int ADDR_WIDTH        = 6
);
    logic                                Start;
    logic        [ADDR_WIDTH-1:0]        Base_Addr;
    logic        [SIZE-1:0]              In_Valid;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_0;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_1;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_2;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_3;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_4;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_5;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_6;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In_7;

    logic                                Wr_en;
    logic        [ADDR_WIDTH-1:0]        Wr_Addr;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_0;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_1;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_2;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_3;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_4;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_5;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_6;
    logic        [PARTIAL_SUM_WIDTH-1:0] Wr_Data_7;
    logic                                Busy;
    logic                                Done;
    logic                                Skew_Err;

    modport master (
        output Start, Base_Addr, In_Valid,
        output Psum_In_0, Psum_In_1, Psum_In_2, Psum_In_3,
        output Psum_In_4, Psum_In_5, Psum_In_6, Psum_In_7,
        input  Wr_en, Wr_Addr,
        input  Wr_Data_0, Wr_Data_1, Wr_Data_2, Wr_Data_3,
        input  Wr_Data_4, Wr_Data_5, Wr_Data_6, Wr_Data_7,
        input  Busy, Done, Skew_Err
    );

    modport slave (
        input  Start, Base_Addr, In_Valid,
        input  Psum_In_0, Psum_In_1, Psum_In_2, Psum_In_3,
        input  Psum_In_4, Psum_In_5, Psum_In_6, Psum_In_7,
        output Wr_en, Wr_Addr,
        output Wr_Data_0, Wr_Data_1, Wr_Data_2, Wr_Data_3,
        output Wr_Data_4, Wr_Data_5, Wr_Data_6, Wr_Data_7,
        output Busy, Done, Skew_Err
    );
endinterface

// File: rtl/psum_collector.sv
// ---------------------------------------------------------------------------
// psum_collector
//   De-skews the column partial sums leaving the bottom of the systolic array
//   and writes one aligned row per cycle into the unified buffer. Column j of
//   a row leaves the array j cycles after column 0, so column j is delayed by
//   SIZE-1-j stages; all columns then share one output register.
//
//   Ports:
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset (clears control, delay lines
//                and outputs)
//     bus      : psum_collector_if.slave
//                Start/Base_Addr open a tile, In_Valid/Psum_In_* carry the
//                skewed columns, Wr_en/Wr_Addr/Wr_Data_* form the buffer
//                write port, Busy/Done/Skew_Err report tile status.
// ---------------------------------------------------------------------------
module psum_collector #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 2*SIZE+$clog2(SIZE),
    parameter int ROWS              = 8,
    parameter int ADDR_WIDTH        = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    psum_collector_if.slave  bus
);
    localparam int PSW   = PARTIAL_SUM_WIDTH;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [PSW-1:0]        psum_in    [SIZE];
    logic signed [PSW-1:0]        align_data [SIZE];
    logic        [SIZE-1:0]       align_vld;

    logic        [ADDR_WIDTH-1:0] addr_q;
    logic        [ADDR_WIDTH-1:0] addr_nxt;
    logic        [CNT_W-1:0]      row_cnt;
    logic        [CNT_W-1:0]      row_cnt_nxt;
    logic                         err_q;
    logic                         err_nxt;
    logic                         do_write;
    logic                         last_write;
    logic                         start_ok;

    logic                         wr_en_p;
    logic                         done_p;
    logic        [ADDR_WIDTH-1:0] wr_addr_p;
    logic signed [PSW-1:0]        wr_data_p  [SIZE];

    assign psum_in[0] = bus.Psum_In_0;
    assign psum_in[1] = bus.Psum_In_1;
    assign psum_in[2] = bus.Psum_In_2;
    assign psum_in[3] = bus.Psum_In_3;
    assign psum_in[4] = bus.Psum_In_4;
    assign psum_in[5] = bus.Psum_In_5;
    assign psum_in[6] = bus.Psum_In_6;
    assign psum_in[7] = bus.Psum_In_7;

    // ---- de-skew stages: column j is delayed SIZE-1-j cycles ----
    for (genvar j = 0; j < SIZE; j++) begin : g_col
        localparam int DEPTH = SIZE - 1 - j;
        if (DEPTH == 0) begin : g_direct
            // Last column arrives already aligned and feeds the output
            // register straight from the port.
            assign align_data[j] = psum_in[j];
            assign align_vld[j]  = bus.In_Valid[j];
        end else begin : g_delay
            logic signed [PSW-1:0]   dly_data_p [DEPTH];
            logic        [DEPTH-1:0] dly_vld_p;

            // Stages shift every cycle; valid is masked outside a tile so
            // stray array output never lines up into a write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dly_data_p[k] <= '0;
                    end
                    dly_vld_p <= '0;
                end else begin
                    dly_data_p[0] <= psum_in[j];
                    dly_vld_p[0]  <= bus.In_Valid[j] && (state == ACTIVE);
                    for (int k = 1; k < DEPTH; k++) begin
                        dly_data_p[k] <= dly_data_p[k-1];
                        dly_vld_p[k]  <= dly_vld_p[k-1];
                    end
                end
            end

            assign align_data[j] = dly_data_p[DEPTH-1];
            assign align_vld[j]  = dly_vld_p[DEPTH-1];
        end
    end

    // ---- tile control: next state, address, row count, error ----
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        row_cnt_nxt = row_cnt;
        err_nxt     = err_q;

        do_write   = (state == ACTIVE) && (&align_vld);
        last_write = do_write && (row_cnt == CNT_W'(ROWS - 1));
        // A Start is honoured when idle, or when it coincides with the
        // final write so the next tile can follow without a gap.
        start_ok   = bus.Start && ((state == IDLE) || last_write);

        if (do_write) begin
            addr_nxt    = addr_q + ADDR_WIDTH'(SIZE);
            row_cnt_nxt = row_cnt + 1'b1;
        end
        if (last_write) begin
            state_nxt = IDLE;
        end
        // Some but not all columns valid at alignment: the row is torn.
        if ((state == ACTIVE) && (|align_vld) && !(&align_vld)) begin
            err_nxt = 1'b1;
        end
        if (start_ok) begin
            state_nxt   = ACTIVE;
            addr_nxt    = bus.Base_Addr;
            row_cnt_nxt = '0;
            err_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            row_cnt <= '0;
            err_q   <= 1'b0;
            wr_en_p <= 1'b0;
            done_p  <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            row_cnt <= row_cnt_nxt;
            err_q   <= err_nxt;
            wr_en_p <= do_write;
            done_p  <= last_write;
        end
    end

    // ---- output register: loads only on a write, holds otherwise ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_p <= '0;
            for (int j = 0; j < SIZE; j++) begin
                wr_data_p[j] <= '0;
            end
        end else if (do_write) begin
            wr_addr_p <= addr_q;
            for (int j = 0; j < SIZE; j++) begin
                wr_data_p[j] <= align_data[j];
            end
        end
    end

    assign bus.Wr_en     = wr_en_p;
    assign bus.Wr_Addr   = wr_addr_p;
    assign bus.Wr_Data_0 = wr_data_p[0];
    assign bus.Wr_Data_1 = wr_data_p[1];
    assign bus.Wr_Data_2 = wr_data_p[2];
    assign bus.Wr_Data_3 = wr_data_p[3];
    assign bus.Wr_Data_4 = wr_data_p[4];
    assign bus.Wr_Data_5 = wr_data_p[5];
    assign bus.Wr_Data_6 = wr_data_p[6];
    assign bus.Wr_Data_7 = wr_data_p[7];
    assign bus.Done      = done_p;
    assign bus.Skew_Err  = err_q;
    // Busy covers the cycle of the final write and drops the cycle after.
    assign bus.Busy      = (state == ACTIVE) || done_p;

endmodule

// File: tb/tb_psum_collector.sv
// ---------------------------------------------------------------------------
// tb_psum_collector
//   Drives skewed rows into psum_collector and compares every cycle against
//   a reference that aligns columns by arrival time (column j of a row is
//   taken j cycles after column 0) and applies the tile rules directly.
//   Scenario-specific expectations (addresses, data, Done) are also checked
//   against constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_psum_collector;
    localparam int SIZE = 8;
    localparam int PSW  = 19;
    localparam int AW   = 6;
    localparam int ROWS = 8;

    typedef logic [8*PSW+AW+3:0] snap_t;
    typedef struct packed {
        logic [31:0]      cyc;
        logic [AW-1:0]    addr;
        logic             done;
        logic [8*PSW-1:0] d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    psum_collector_if #(.SIZE(SIZE), .PARTIAL_SUM_WIDTH(PSW), .ADDR_WIDTH(AW)) bus ();

    psum_collector #(
        .SIZE(SIZE), .PARTIAL_SUM_WIDTH(PSW), .ROWS(ROWS), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // drive state
    logic [7:0]     cur_v;
    logic [PSW-1:0] cur_d [8];
    logic           cur_start;
    logic [AW-1:0]  cur_base;

    // reference model state
    logic [7:0]     hv [16];
    logic [PSW-1:0] hd [16][8];
    int             ecount;
    logic           m_active;
    logic [AW-1:0]  m_addr;
    int             m_cnt;
    logic           m_err;
    logic           e_we, e_done, e_err, e_busy;
    logic [AW-1:0]  e_addr;
    logic [PSW-1:0] e_data [8];

    snap_t obs_q[$];
    snap_t exp_q[$];
    wr_t   wr_log[$];

    task automatic apply();
        bus.In_Valid  = cur_v;
        bus.Psum_In_0 = cur_d[0];
        bus.Psum_In_1 = cur_d[1];
        bus.Psum_In_2 = cur_d[2];
        bus.Psum_In_3 = cur_d[3];
        bus.Psum_In_4 = cur_d[4];
        bus.Psum_In_5 = cur_d[5];
        bus.Psum_In_6 = cur_d[6];
        bus.Psum_In_7 = cur_d[7];
        bus.Start     = cur_start;
        bus.Base_Addr = cur_base;
    endtask

    function automatic logic [8*PSW-1:0] dut_data();
        return {bus.Wr_Data_7, bus.Wr_Data_6, bus.Wr_Data_5, bus.Wr_Data_4,
                bus.Wr_Data_3, bus.Wr_Data_2, bus.Wr_Data_1, bus.Wr_Data_0};
    endfunction

    function automatic snap_t snap_dut();
        return {bus.Wr_en, bus.Wr_Addr, bus.Done, bus.Skew_Err, bus.Busy, dut_data()};
    endfunction

    function automatic snap_t snap_exp();
        return {e_we, e_addr, e_done, e_err, e_busy,
                e_data[7], e_data[6], e_data[5], e_data[4],
                e_data[3], e_data[2], e_data[1], e_data[0]};
    endfunction

    function automatic logic [PSW-1:0] neg_val(input int r, input int j);
        return (((r + j) % 2) != 0) ? {PSW{1'b1}} : {1'b1, {(PSW-1){1'b0}}};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            hv[s] = '0;
            for (int j = 0; j < 8; j++) hd[s][j] = '0;
        end
        ecount = 0; m_active = 0; m_addr = '0; m_cnt = 0; m_err = 0;
        e_we = 0; e_done = 0; e_err = 0; e_busy = 0; e_addr = '0;
        for (int j = 0; j < 8; j++) e_data[j] = '0;
    endtask

    // One clock edge of the reference: record arrivals, align by arrival
    // time, then apply the tile rules.
    task automatic model_edge();
        logic [7:0]     av;
        logic [PSW-1:0] ad [8];
        logic           wr, last, st;
        int             s;
        s = ecount & 15;
        for (int j = 0; j < 8; j++) begin
            hv[s][j] = cur_v[j] && (j == 7 || m_active);
            hd[s][j] = cur_d[j];
        end
        for (int j = 0; j < 8; j++) begin
            s = (ecount - (7 - j)) & 15;
            av[j] = hv[s][j];
            ad[j] = hd[s][j];
        end
        wr   = m_active && (av == 8'hFF);
        last = wr && (m_cnt == ROWS - 1);
        st   = cur_start && (!m_active || last);
        e_we   = wr;
        e_done = last;
        if (wr) begin
            e_addr = m_addr;
            e_data = ad;
            m_addr = m_addr + 6'd8;
            m_cnt++;
        end
        if (m_active && av != 8'h00 && av != 8'hFF) m_err = 1;
        if (last) m_active = 0;
        if (st) begin
            m_active = 1; m_addr = cur_base; m_cnt = 0; m_err = 0;
        end
        e_err  = m_err;
        e_busy = m_active || e_done;
        ecount++;
    endtask

    task automatic cycle(input int t);
        wr_t w;
        apply();
        model_edge();
        @(posedge clk);
        #1;
        obs_q.push_back(snap_dut());
        exp_q.push_back(snap_exp());
        if (bus.Wr_en === 1'b1) begin
            w.cyc = 32'(t); w.addr = bus.Wr_Addr; w.done = bus.Done; w.d = dut_data();
            wr_log.push_back(w);
        end
        cur_start = 1'b0;
    endtask

    task automatic clear_logs();
        obs_q.delete(); exp_q.delete(); wr_log.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        cur_start = 1'b1;
        cur_base  = base;
        cur_v     = 8'($urandom);
        for (int j = 0; j < 8; j++) cur_d[j] = PSW'($urandom);
        cycle(-1);
        cur_v = '0;
    endtask

    // Feeds n skewed rows: row r column j is presented at feed cycle r+j.
    // mode 0: 100*r+j, 1: random, 2: alternating -1 / -(2^18).
    task automatic feed(input int n, input int mode, input int drop_row, input int drop_col,
                        input int start_t, input logic [AW-1:0] start_base, input int ncyc);
        logic [PSW-1:0] rows [16][8];
        int total, r;
        for (int rr = 0; rr < n; rr++) begin
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0:       rows[rr][j] = PSW'(100*rr + j);
                    1:       rows[rr][j] = PSW'($urandom);
                    default: rows[rr][j] = neg_val(rr, j);
                endcase
            end
        end
        total = (ncyc > 0) ? ncyc : n + SIZE;
        for (int t = 0; t < total; t++) begin
            for (int j = 0; j < 8; j++) begin
                r = t - j;
                if (r >= 0 && r < n) begin
                    cur_v[j] = !(r == drop_row && j == drop_col);
                    cur_d[j] = rows[r][j];
                end else begin
                    cur_v[j] = 1'b0;
                    cur_d[j] = PSW'($urandom);
                end
            end
            cur_start = (t == start_t);
            if (t == start_t) cur_base = start_base;
            cycle(t);
        end
        cur_v = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (bus.Wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", bus.Wr_en); end
        vectors++; if (bus.Wr_Addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr: got %0d want 0", bus.Wr_Addr); end
        vectors++; if (dut_data() !== '0) begin miscompares++; $display("FAIL reset_wr_data: got %h want 0", dut_data()); end
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        vectors++; if (bus.Skew_Err !== 1'b0) begin miscompares++; $display("FAIL reset_skew_err: got %b want 0", bus.Skew_Err); end
        model_reset();
        #1 rst_n = 1'b1;
        clear_logs();
        for (int t = 0; t < 3; t++) cycle(t);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL reset_idle cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_single_tile();
        clear_logs();
        do_start(6'd0);
        feed(8, 0, -1, -1, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL single_tile cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (wr_log.size() !== 8) begin miscompares++; $display("FAIL single_tile_count: got %0d want 8", wr_log.size()); end
        foreach (wr_log[r]) begin
            vectors++;
            if (wr_log[r].addr !== 6'(8*r) || wr_log[r].cyc !== 32'(7 + r) || wr_log[r].done !== (r == 7)) begin
                miscompares++;
                $display("FAIL single_tile_row %0d: got addr %0d cyc %0d done %b want addr %0d cyc %0d done %b",
                         r, wr_log[r].addr, wr_log[r].cyc, wr_log[r].done, 8*r, 7 + r, (r == 7));
            end
            for (int j = 0; j < 8; j++) begin
                vectors++;
                if (wr_log[r].d[j*PSW +: PSW] !== PSW'(100*r + j)) begin
                    miscompares++;
                    $display("FAIL single_tile_data r%0d c%0d: got %0d want %0d", r, j, wr_log[r].d[j*PSW +: PSW], 100*r + j);
                end
            end
        end
        vectors++;
        if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL single_tile_busy_after: got %b want 0", bus.Busy); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [8];
        exp_a = '{6'd48, 6'd56, 6'd0, 6'd8, 6'd16, 6'd24, 6'd32, 6'd40};
        clear_logs();
        do_start(6'd48);
        feed(8, 1, -1, -1, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL wrap cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (wr_log.size() !== 8) begin miscompares++; $display("FAIL wrap_count: got %0d want 8", wr_log.size()); end
        for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
            vectors++;
            if (wr_log[k].addr !== exp_a[k]) begin
                miscompares++; $display("FAIL wrap_addr %0d: got %0d want %0d", k, wr_log[k].addr, exp_a[k]);
            end
        end
    endtask

    task automatic test_skew();
        clear_logs();
        do_start(6'd24);
        // Row 3 column 5 misses its slot; a ninth row closes the tile.
        feed(9, 0, 3, 5, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL skew cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (wr_log.size() !== 8) begin miscompares++; $display("FAIL skew_count: got %0d want 8", wr_log.size()); end
        foreach (wr_log[k]) begin
            vectors++;
            if (wr_log[k].d[0 +: PSW] === PSW'(300)) begin
                miscompares++; $display("FAIL skew_row3_written: got row at addr %0d want no write", wr_log[k].addr);
            end
        end
        vectors++;
        if (bus.Skew_Err !== 1'b1) begin miscompares++; $display("FAIL skew_err_held: got %b want 1", bus.Skew_Err); end
        clear_logs();
        do_start(6'd0);
        vectors++;
        if (bus.Skew_Err !== 1'b0) begin miscompares++; $display("FAIL skew_err_clear: got %b want 0", bus.Skew_Err); end
        feed(8, 1, -1, -1, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL skew_recover cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_idle_ignore();
        clear_logs();
        feed(8, 1, -1, -1, -1, '0, 0);
        vectors++;
        if (wr_log.size() !== 0) begin miscompares++; $display("FAIL idle_writes: got %0d want 0", wr_log.size()); end
        do_start(6'd16);
        // Start mid-tile must not move the address or row count.
        feed(8, 1, -1, -1, 4, 6'd40, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL idle_ignore cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (wr_log.size() !== 8) begin miscompares++; $display("FAIL midstart_count: got %0d want 8", wr_log.size()); end
        foreach (wr_log[k]) begin
            vectors++;
            if (wr_log[k].addr !== 6'(16 + 8*k)) begin
                miscompares++; $display("FAIL midstart_addr %0d: got %0d want %0d", k, wr_log[k].addr, (16 + 8*k) % 64);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        do_start(6'd0);
        feed(8, 0, -1, -1, -1, '0, 12);
        vectors++;
        if (wr_log.size() !== 5) begin miscompares++; $display("FAIL rstmid_pre_count: got %0d want 5", wr_log.size()); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.Wr_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_wr_en: got %b want 0", bus.Wr_en); end
        vectors++; if (bus.Wr_Addr !== '0) begin miscompares++; $display("FAIL rstmid_wr_addr: got %0d want 0", bus.Wr_Addr); end
        vectors++; if (dut_data() !== '0) begin miscompares++; $display("FAIL rstmid_wr_data: got %h want 0", dut_data()); end
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", bus.Busy); end
        vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b want 0", bus.Done); end
        model_reset();
        #1 rst_n = 1'b1;
        clear_logs();
        feed(8, 1, -1, -1, -1, '0, 0);
        vectors++;
        if (wr_log.size() !== 0) begin miscompares++; $display("FAIL rstmid_inflight: got %0d writes want 0", wr_log.size()); end
        do_start(6'd8);
        feed(8, 0, -1, -1, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rstmid cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (wr_log.size() !== 8 || wr_log[0].addr !== 6'd8) begin
            miscompares++; $display("FAIL rstmid_restart: got %0d writes first addr %0d want 8 writes first addr 8",
                                    wr_log.size(), (wr_log.size() > 0) ? wr_log[0].addr : 6'd0);
        end
    endtask

    task automatic test_negative();
        clear_logs();
        do_start(6'd32);
        feed(8, 2, -1, -1, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL negative cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        foreach (wr_log[r]) begin
            for (int j = 0; j < 8; j++) begin
                vectors++;
                if (wr_log[r].d[j*PSW +: PSW] !== neg_val(r, j)) begin
                    miscompares++;
                    $display("FAIL negative_data r%0d c%0d: got %h want %h", r, j, wr_log[r].d[j*PSW +: PSW], neg_val(r, j));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] base_b;
        int dones;
        base_b = 6'($urandom);
        clear_logs();
        do_start(6'd62);
        // Final write of a 9-row tile is decided at feed cycle 15; Start
        // arrives in that same cycle and must both open a tile and clear
        // the error raised by the torn row 2.
        feed(9, 1, 2, 4, 15, base_b, 0);
        vectors++;
        if (bus.Skew_Err !== 1'b0) begin miscompares++; $display("FAIL b2b_err_clear: got %b want 0", bus.Skew_Err); end
        feed(8, 1, -1, -1, -1, '0, 0);
        foreach (obs_q[i]) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL b2b cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        dones = 0;
        vectors++;
        if (wr_log.size() !== 16) begin miscompares++; $display("FAIL b2b_count: got %0d want 16", wr_log.size()); end
        foreach (wr_log[k]) begin
            if (wr_log[k].done) dones++;
            vectors++;
            if (wr_log[k].addr !== ((k < 8) ? 6'(62 + 8*k) : 6'(base_b + 6'(8*(k-8))))) begin
                miscompares++; $display("FAIL b2b_addr %0d: got %0d want %0d", k, wr_log[k].addr,
                                        (k < 8) ? 6'(62 + 8*k) : 6'(base_b + 6'(8*(k-8))));
            end
        end
        vectors++;
        if (dones !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
    endtask

    task automatic test_random();
        int drop;
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            do_start(6'($urandom));
            feed((drop >= 0) ? 9 : 8, 1, drop, int'($urandom_range(0, 7)), -1, '0, 0);
            foreach (obs_q[i]) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL random it%0d cycle %0d: got %h want %h", it, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        cur_v = '0; cur_start = 1'b0; cur_base = '0;
        for (int j = 0; j < 8; j++) cur_d[j] = '0;
        apply();
        test_reset();
        test_single_tile();
        test_wrap();
        test_skew();
        test_idle_ignore();
        test_reset_mid();
        test_negative();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
